// File: rtl/mcycle_control.sv
// Multicycle control sequencer: owns the main state register, walks each
// instruction through fetch / decode / execute / writeback, decodes the
// per-state datapath strobes and counts retired instructions.
module mcycle_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           nextstate,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic [3:0]           state,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 iord,
    output logic                 irwrite,
    output logic                 pcen,
    output logic [1:0]           pcsrc,
    output logic [1:0]           aluphase,
    output logic                 regwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] instret
);

    // Shared EXMODE state encodings
    localparam logic [3:0] FETCH1  = 4'd0;
    localparam logic [3:0] FETCH2  = 4'd1;
    localparam logic [3:0] DECODE  = 4'd2;
    localparam logic [3:0] LBRD    = 4'd3;
    localparam logic [3:0] LBWR    = 4'd4;
    localparam logic [3:0] SBWR    = 4'd5;
    localparam logic [3:0] RTYPEEX = 4'd6;
    localparam logic [3:0] RTYPEWR = 4'd7;
    localparam logic [3:0] BEQEX   = 4'd8;
    localparam logic [3:0] JEX     = 4'd9;
    localparam logic [3:0] ADDIEX  = 4'd10;
    localparam logic [3:0] ADDIWR  = 4'd11;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [3:0] next_state_s;
    logic       retire_s;
    logic       bad_dispatch_s;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH1;
        end else begin
            state <= next_state_s;
        end
    end

    // Next-state logic plus retire / bad-dispatch qualifiers for the counter
    always_comb begin
        next_state_s   = FETCH1;
        retire_s       = 1'b0;
        bad_dispatch_s = 1'b0;
        case (state)
            FETCH1:  next_state_s = FETCH2;
            FETCH2: begin
                if (mem_ready) begin
                    next_state_s = DECODE;
                end else begin
                    next_state_s = FETCH2;
                end
            end
            DECODE: begin
                case (nextstate)
                    LBRD, SBWR, RTYPEEX, BEQEX, JEX, ADDIEX: next_state_s = nextstate;
                    default: begin
                        // FETCH1 is the decoder's unknown-opcode marker; any
                        // other non-dispatch code is treated the same way
                        next_state_s   = FETCH1;
                        bad_dispatch_s = 1'b1;
                    end
                endcase
            end
            LBRD: begin
                if (mem_ready) begin
                    next_state_s = LBWR;
                end else begin
                    next_state_s = LBRD;
                end
            end
            LBWR: begin
                next_state_s = FETCH1;
                retire_s     = 1'b1;
            end
            SBWR: begin
                if (mem_ready) begin
                    next_state_s = FETCH1;
                    retire_s     = 1'b1;
                end else begin
                    next_state_s = SBWR;
                end
            end
            RTYPEEX: next_state_s = RTYPEWR;
            RTYPEWR: begin
                next_state_s = FETCH1;
                retire_s     = 1'b1;
            end
            ADDIEX:  next_state_s = ADDIWR;
            ADDIWR: begin
                next_state_s = FETCH1;
                retire_s     = 1'b1;
            end
            BEQEX: begin
                next_state_s = FETCH1;
                retire_s     = 1'b1;
            end
            JEX: begin
                next_state_s = FETCH1;
                retire_s     = 1'b1;
            end
            default: next_state_s = FETCH1;  // unused codes recover to fetch
        endcase
    end

    // Datapath strobes decoded from the current state (plus mem_ready/zero)
    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcen     = 1'b0;
        pcsrc    = 2'b00;
        aluphase = 2'b00;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        case (state)
            FETCH1:  memread = 1'b1;
            FETCH2: begin
                memread = 1'b1;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                end else begin
                    irwrite = 1'b0;
                    pcen    = 1'b0;
                end
            end
            DECODE:  aluphase = 2'b01;
            LBRD: begin
                aluphase = 2'b10;
                memread  = 1'b1;
                iord     = 1'b1;
            end
            LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            SBWR: begin
                aluphase = 2'b10;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            RTYPEEX: aluphase = 2'b10;
            RTYPEWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            ADDIEX:  aluphase = 2'b10;
            ADDIWR:  regwrite = 1'b1;
            BEQEX: begin
                aluphase = 2'b10;
                pcsrc    = 2'b01;
                pcen     = zero;
            end
            JEX: begin
                pcen  = 1'b1;
                pcsrc = 2'b10;
            end
            default: memread = 1'b0;
        endcase
    end

    // Retired-instruction counter (wraps) and sticky illegal-dispatch flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            if (retire_s) begin
                instret <= instret + CNT_ONE;
            end else begin
                instret <= instret;
            end
            illegal <= illegal | bad_dispatch_s;
        end
    end

endmodule

// File: tb/tb_mcycle_control.sv
// Self-checking bench for mcycle_control: an instruction-level planner expands
// each instruction (kind, stall counts, zero flag) into the per-cycle states
// and strobes it must produce; two instances (16-bit and 4-bit counters) run
// the same stimulus.
module tb_mcycle_control;

    logic        clk;
    logic        reset;
    logic [3:0]  nextstate;
    logic        zero;
    logic        mem_ready;

    logic [3:0]  state, state4;
    logic        memread, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, illegal;
    logic [1:0]  pcsrc, aluphase;
    logic [15:0] instret;
    logic        memread4, memwrite4, iord4, irwrite4, pcen4, regwrite4, regdst4, memtoreg4, illegal4;
    logic [1:0]  pcsrc4, aluphase4;
    logic [3:0]  instret4;

    mcycle_control dut (
        .clk(clk), .reset(reset), .nextstate(nextstate), .zero(zero), .mem_ready(mem_ready),
        .state(state), .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcen(pcen), .pcsrc(pcsrc), .aluphase(aluphase), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .illegal(illegal), .instret(instret)
    );

    mcycle_control #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .nextstate(nextstate), .zero(zero), .mem_ready(mem_ready),
        .state(state4), .memread(memread4), .memwrite(memwrite4), .iord(iord4), .irwrite(irwrite4),
        .pcen(pcen4), .pcsrc(pcsrc4), .aluphase(aluphase4), .regwrite(regwrite4), .regdst(regdst4),
        .memtoreg(memtoreg4), .illegal(illegal4), .instret(instret4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector: memread memwrite iord irwrite pcen pcsrc[2] aluphase[2] regwrite regdst memtoreg
    localparam logic [11:0] O_F1    = 12'b1_0_0_0_0_00_00_0_0_0;
    localparam logic [11:0] O_F2R   = 12'b1_0_0_1_1_00_00_0_0_0;
    localparam logic [11:0] O_DEC   = 12'b0_0_0_0_0_00_01_0_0_0;
    localparam logic [11:0] O_LBRD  = 12'b1_0_1_0_0_00_10_0_0_0;
    localparam logic [11:0] O_LBWR  = 12'b0_0_0_0_0_00_00_1_0_1;
    localparam logic [11:0] O_SB    = 12'b0_1_1_0_0_00_10_0_0_0;
    localparam logic [11:0] O_EX    = 12'b0_0_0_0_0_00_10_0_0_0;
    localparam logic [11:0] O_RWR   = 12'b0_0_0_0_0_00_00_1_1_0;
    localparam logic [11:0] O_AWR   = 12'b0_0_0_0_0_00_00_1_0_0;
    localparam logic [11:0] O_BEQ0  = 12'b0_0_0_0_0_01_10_0_0_0;
    localparam logic [11:0] O_BEQ1  = 12'b0_0_0_0_1_01_10_0_0_0;
    localparam logic [11:0] O_J     = 12'b0_0_0_0_1_10_00_0_0_0;

    localparam int K_LB = 0, K_SB = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

    typedef struct {
        logic       mr;
        logic [3:0] ns;
        logic       z;
        logic [3:0] st;
        logic [11:0] o;
        logic       ill;
        int         cnt;
    } step_t;

    step_t plan[$];
    int    m_cnt;
    logic  m_ill;
    int    n_checks;
    int    n_pass;
    int    obs_rw, obs_mw, obs_pcen_f2;
    logic [7:0] obs_rd;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rn();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [11:0] outs();
        return {memread, memwrite, iord, irwrite, pcen, pcsrc, aluphase, regwrite, regdst, memtoreg};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic mr, input logic [3:0] ns, input logic z,
                        input logic [3:0] st, input logic [11:0] o);
        step_t s;
        s.mr = mr; s.ns = ns; s.z = z; s.st = st; s.o = o; s.ill = m_ill; s.cnt = m_cnt;
        plan.push_back(s);
    endtask

    // Expand one instruction into its expected cycle sequence
    task automatic add_instr(input int kind, input int fw, input int mw, input logic z,
                             input logic [3:0] ill_code);
        logic [3:0] code;
        push(rb(), rn(), rb(), 4'd0, O_F1);
        for (int i = 0; i < fw; i++) push(1'b0, rn(), rb(), 4'd1, O_F1);
        push(1'b1, rn(), rb(), 4'd1, O_F2R);
        case (kind)
            K_LB:    code = 4'd3;
            K_SB:    code = 4'd5;
            K_R:     code = 4'd6;
            K_ADDI:  code = 4'd10;
            K_BEQ:   code = 4'd8;
            K_J:     code = 4'd9;
            default: code = ill_code;
        endcase
        push(rb(), code, rb(), 4'd2, O_DEC);
        case (kind)
            K_LB: begin
                for (int i = 0; i < mw; i++) push(1'b0, rn(), rb(), 4'd3, O_LBRD);
                push(1'b1, rn(), rb(), 4'd3, O_LBRD);
                push(rb(), rn(), rb(), 4'd4, O_LBWR);
                m_cnt++;
            end
            K_SB: begin
                for (int i = 0; i < mw; i++) push(1'b0, rn(), rb(), 4'd5, O_SB);
                push(1'b1, rn(), rb(), 4'd5, O_SB);
                m_cnt++;
            end
            K_R: begin
                push(rb(), rn(), rb(), 4'd6, O_EX);
                push(rb(), rn(), rb(), 4'd7, O_RWR);
                m_cnt++;
            end
            K_ADDI: begin
                push(rb(), rn(), rb(), 4'd10, O_EX);
                push(rb(), rn(), rb(), 4'd11, O_AWR);
                m_cnt++;
            end
            K_BEQ: begin
                push(rb(), rn(), z, 4'd8, z ? O_BEQ1 : O_BEQ0);
                m_cnt++;
            end
            K_J: begin
                push(rb(), rn(), rb(), 4'd9, O_J);
                m_cnt++;
            end
            default: m_ill = 1'b1;
        endcase
    endtask

    // Apply the planned cycles; entered and left at a falling edge
    task automatic run_plan(input string tag);
        obs_rw = 0; obs_mw = 0; obs_pcen_f2 = 0; obs_rd = 8'h00;
        for (int i = 0; i < plan.size(); i++) begin
            mem_ready = plan[i].mr;
            nextstate = plan[i].ns;
            zero      = plan[i].z;
            #1;
            check($sformatf("%s step %0d {st,out,ill,cnt16,cnt4,st4}", tag, i),
                  64'({state, outs(), illegal, instret, instret4, state4}),
                  64'({plan[i].st, plan[i].o, plan[i].ill, 16'(plan[i].cnt), 4'(plan[i].cnt), plan[i].st}));
            if (regwrite) begin
                obs_rw++;
                obs_rd = {obs_rd[6:0], regdst};
            end
            if (memwrite) obs_mw++;
            if (pcen && state == 4'd1) obs_pcen_f2++;
            @(negedge clk);
        end
        plan.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_cnt = 0;
        m_ill = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        reset = 1'b1; nextstate = 4'd0; zero = 1'b0; mem_ready = 1'b0;
        m_cnt = 0; m_ill = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset state", 64'({state, outs(), illegal, instret, instret4}),
              64'({4'd0, O_F1, 1'b0, 16'd0, 4'd0}));
        reset = 1'b0;
        m_cnt = 0; m_ill = 1'b0;

        // Straight-line program: R, ADDI, LB, SB, BEQ, J with no stalls
        add_instr(K_R, 0, 0, 1'b0, 4'd0);
        add_instr(K_ADDI, 0, 0, 1'b0, 4'd0);
        add_instr(K_LB, 0, 0, 1'b0, 4'd0);
        add_instr(K_SB, 0, 0, 1'b0, 4'd0);
        add_instr(K_BEQ, 0, 0, 1'b1, 4'd0);
        add_instr(K_J, 0, 0, 1'b0, 4'd0);
        check("program cycle count", 64'(plan.size()), 64'd27);
        run_plan("prog");
        #1;
        check("instret after program", 64'(instret), 64'd6);
        check("regwrite pulses", 64'(obs_rw), 64'd3);
        check("regdst order", 64'(obs_rd[2:0]), 64'(3'b100));

        // Illegal dispatch with code 0 and 13, then a legal instruction
        add_instr(K_ILL, 0, 0, 1'b0, 4'd0);
        add_instr(K_ILL, 0, 0, 1'b0, 4'd13);
        add_instr(K_R, 0, 0, 1'b0, 4'd0);
        run_plan("illegal");
        #1;
        check("illegal sticky", 64'(illegal), 64'd1);
        check("instret after illegal", 64'(instret), 64'd7);

        // Memory stalls of 3 cycles in FETCH2 and SBWR
        add_instr(K_SB, 3, 3, 1'b0, 4'd0);
        run_plan("stall");
        check("memwrite cycles", 64'(obs_mw), 64'd4);
        check("pcen pulses in FETCH2", 64'(obs_pcen_f2), 64'd1);

        // BEQ taken and not taken, LB with read stall
        add_instr(K_BEQ, 0, 0, 1'b1, 4'd0);
        add_instr(K_BEQ, 0, 0, 1'b0, 4'd0);
        add_instr(K_LB, 1, 2, 1'b0, 4'd0);
        run_plan("beq");

        // Asynchronous reset in the middle of LBRD
        mem_ready = 1'b1; nextstate = 4'd3;
        @(negedge clk); @(negedge clk); @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("in LBRD before reset", 64'({state, outs()}), 64'({4'd3, O_LBRD}));
        #2;
        reset = 1'b1;
        #1;
        check("async reset mid-LBRD", 64'({state, memread, memwrite, illegal, instret, instret4}),
              64'({4'd0, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0}));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first edge after release", 64'(state), 64'd1);

        // Counter wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 17; i++) add_instr(K_J, 0, 0, 1'b0, 4'd0);
        run_plan("wrap");
        #1;
        check("instret4 wrap", 64'(instret4), 64'd1);
        check("instret16 no wrap", 64'(instret), 64'd17);

        // Randomized instruction mix with random stalls and ignored-input noise
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 6);
            add_instr(k, $urandom_range(0, 2), $urandom_range(0, 2), rb(),
                      (k == K_ILL) ? 4'($urandom_range(11, 15)) : 4'd0);
        end
        run_plan("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
